pipe_fetch_decode: RTL and testbench
====================================

PIPE_FETCH_DECODE -- requirements
Module: pipe_fetch_decode

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous reset, active low; sampled on rising edge of clk.
REQ-003 start  input  1  begin fetching at start_pc; honoured in IDLE and HALT only.
REQ-004 start_pc  input  8  first instruction address.
REQ-005 stall  input  1  downstream hold request.
REQ-006 prog_we, prog_addr[7:0], prog_data[23:0]  input  instruction-memory write port.
REQ-007 rs1, rs2, rd, func  output  4 each  decoded register/function fields to the register-read stage.
REQ-008 addr  output  8  decoded memory address field.
REQ-009 valid  output  1  decoded fields hold a real instruction.
REQ-010 pc_out  output  8  address of the instruction currently presented.
REQ-011 busy, halted  output  1 each  state==RUN, state==HALT.

Function
REQ-012 Internal 256 x 24 instruction memory, no reset, contents retained across rst_n.
REQ-013 Instruction format: [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr.
REQ-014 8-bit program counter pc; increment wraps 0xFF -> 0x00.
REQ-015 FSM states IDLE, RUN, HALT.
REQ-016 IDLE/HALT with start=1: pc <= start_pc, go to RUN; valid stays 0 that edge.
REQ-017 RUN, stall=0, each edge: decode imem[pc] (combinational read).
REQ-018 Normal func (0x0-0xD): fields registered to outputs, valid <= 1, pc_out <= pc, pc <= pc+1.
REQ-019 func 0xE (jump): consumed, not forwarded; valid <= 0, pc <= addr field.
REQ-020 func 0xF (halt): valid <= 0, pc unchanged, go to HALT.
REQ-021 func 0xC/0xD are forwarded unchanged; the downstream stage handles them.
REQ-022 Latency: instruction at start_pc appears with valid=1 after the second edge following start sampled.
REQ-023 RUN, stall=1: pc, state and all outputs (including valid) hold.
REQ-024 stall has no effect in IDLE/HALT.
REQ-025 start in RUN is ignored.
REQ-026 prog_we=1 in IDLE/HALT: imem[prog_addr] <= prog_data.
REQ-027 prog_we=1 in RUN is ignored; memory is unchanged.
REQ-028 Simultaneous prog_we and start in IDLE: both take effect; the first fetch reads the updated memory.
REQ-029 HALT: valid=0, outputs other than valid hold their last values.

Reset
REQ-030 rst_n=0 at an edge: state IDLE, pc=0, valid=0, pc_out=0.
REQ-031 rst_n=0 at an edge: rs1=rs2=rd=func=0, addr=0, busy=0, halted=0.
REQ-032 Reset overrides start, stall and prog_we in the same cycle.
REQ-033 Reset mid-RUN drops any in-flight instruction; no further valid until a new start.

Verification
REQ-034 Program imem[0]={0,3,1,2,0x10}, imem[1]={1,4,3,1,0x11}, imem[2]=0xF00000; start with start_pc=0:
  - valid=1 for two cycles: pc_out=0 (func0 rd3 rs1=1 rs2=2 addr0x10), then pc_out=1.
  - halted=1 and valid=0 afterwards.
REQ-035 Assert stall for 2 cycles while pc_out=1:
  - outputs and valid frozen for those cycles.
  - pc_out=2 follows on release; no instruction dropped or duplicated.
REQ-036 imem[5]=jump to 0x40, imem[0x40]=add:
  - pc_out=4, then one cycle with valid=0, then pc_out=0x40 with valid=1.
REQ-037 start_pc=0xFF, imem[0xFF]=add, imem[0]=halt:
  - pc_out=0xFF with valid=1, then halted=1; confirms wrap.
REQ-038 Pulse rst_n low mid-RUN:
  - all outputs read 0 after the edge, busy=0.
  - restarting reproduces the identical instruction stream (memory retained).
REQ-039 prog_we to the current pc during RUN: the stream is unchanged and a memory readback after halt shows the old contents.

Source files
------------

// File: rtl/pipe_fetch_decode.sv
// pipe_fetch_decode: fetch/decode stage with a 256x24 instruction memory and IDLE/RUN/HALT control.
module pipe_fetch_decode (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  start_pc,
   input  logic        stall,
   input  logic        prog_we,
   input  logic [7:0]  prog_addr,
   input  logic [23:0] prog_data,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  rd,
   output logic [3:0]  func,
   output logic [7:0]  addr,
   output logic        valid,
   output logic [7:0]  pc_out,
   output logic        busy,
   output logic        halted
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d, pc_out_q, pc_out_d;
   logic        valid_q, valid_d;
   logic [23:0] inst_q, inst_d, ins;
   logic [23:0] imem [256];
   logic        is_jump, is_halt, norm, fire;
   always_ff @(posedge clk)
      if (rst_n && prog_we && state_q != RUN) imem[prog_addr] <= prog_data;
   assign ins     = imem[pc_q];
   assign is_jump = ins[23:20] == 4'hE;
   assign is_halt = ins[23:20] == 4'hF;
   assign norm    = !is_jump && !is_halt;
   assign fire    = state_q == RUN && !stall;
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      inst_d   = inst_q;
      if (state_q != RUN && start) begin
         state_d = RUN;
         pc_d    = start_pc;
      end
      if (fire) begin
         valid_d  = norm;
         state_d  = is_halt ? HALT : RUN;
         pc_d     = is_halt ? pc_q : is_jump ? ins[7:0] : pc_q + 8'd1;
         pc_out_d = norm ? pc_q : pc_out_q;
         inst_d   = norm ? ins : inst_q;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= 8'd0;
         pc_out_q <= 8'd0;
         valid_q  <= 1'b0;
         inst_q   <= 24'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         inst_q   <= inst_d;
      end
   end
   assign func   = inst_q[23:20];
   assign rd     = inst_q[19:16];
   assign rs1    = inst_q[15:12];
   assign rs2    = inst_q[11:8];
   assign addr   = inst_q[7:0];
   assign valid  = valid_q;
   assign pc_out = pc_out_q;
   assign busy   = state_q == RUN;
   assign halted = state_q == HALT;
endmodule

// File: tb/tb_pipe_fetch_decode.sv
// tb_pipe_fetch_decode: scoreboard bench for the fetch/decode stage.
module tb_pipe_fetch_decode;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_pc = 8'd0;
   logic        stall = 1'b0;
   logic        prog_we = 1'b0;
   logic [7:0]  prog_addr = 8'd0;
   logic [23:0] prog_data = 24'd0;
   logic [3:0]  rs1, rs2, rd, func;
   logic [7:0]  addr, pc_out;
   logic        valid, busy, halted;
   int          vec = 0;
   int          miss = 0;
   logic [31:0] sb [$];
   logic        stall_e = 1'b0;

   pipe_fetch_decode dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stall(stall),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
      .valid(valid), .pc_out(pc_out), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) stall_e <= stall;

   always @(negedge clk) begin
      if (valid && !stall_e) begin
         logic [31:0] e;
         vec++;
         if (sb.size() == 0) begin
            miss++;
            $display("FAIL stream: unexpected instruction pc_out=%h got=%h%h%h%h%h required=none", pc_out, func, rd, rs1, rs2, addr);
         end else begin
            e = sb.pop_front();
            if ({pc_out, func, rd, rs1, rs2, addr} !== e) begin
               miss++;
               $display("FAIL stream: got=%h required=%h", {pc_out, func, rd, rs1, rs2, addr}, e);
            end
         end
      end
   end

   function automatic logic [23:0] enc(input logic [3:0] f, r, s1, s2, input logic [7:0] a);
      return {f, r, s1, s2, a};
   endfunction

   task automatic load(input logic [7:0] a, input logic [23:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic go(input logic [7:0] p);
      start = 1'b1;
      start_pc = p;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_inst(input logic [7:0] p, input logic [23:0] d);
      sb.push_back({p, d});
   endtask

   task automatic wait_halt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (halted) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b1;
      stall = 1'b1;
      repeat (2) @(negedge clk);
      vec++;
      if ({func, rd, rs1, rs2, addr, pc_out, valid, busy, halted} !== 35'd0) begin
         miss++;
         $display("FAIL reset_outputs: got=%h required=0", {func, rd, rs1, rs2, addr, pc_out, valid, busy, halted});
      end
      rst_n = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         miss++;
         $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy, valid);
      end
   endtask

   task automatic test_basic;
      bit ok;
      load(8'h00, enc(4'h0, 4'h3, 4'h1, 4'h2, 8'h10));
      load(8'h01, enc(4'h1, 4'h4, 4'h3, 4'h1, 8'h11));
      load(8'h02, 24'hF00000);
      expect_inst(8'h00, 24'h031210);
      expect_inst(8'h01, 24'h143111);
      go(8'h00);
      vec++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
         miss++;
         $display("FAIL latency_first_edge: valid=%b busy=%b required 0 1", valid, busy);
      end
      @(negedge clk);
      vec++;
      if (valid !== 1'b1 || pc_out !== 8'h00 || rs1 !== 4'h1 || rs2 !== 4'h2 || rd !== 4'h3) begin
         miss++;
         $display("FAIL latency_second_edge: valid=%b pc_out=%h required 1 00", valid, pc_out);
      end
      wait_halt(ok);
      vec++;
      if (!ok || valid !== 1'b0) begin
         miss++;
         $display("FAIL basic_halt: halted=%b valid=%b required 1 0", halted, valid);
      end
      @(negedge clk);
      vec++;
      if ({pc_out, func, rd, rs1, rs2, addr} !== 32'h01143111) begin
         miss++;
         $display("FAIL halt_hold: got=%h required=01143111", {pc_out, func, rd, rs1, rs2, addr});
      end
      vec++;
      if (sb.size() != 0) begin
         miss++;
         $display("FAIL basic_drain: pending=%0d required=0", sb.size());
      end
   endtask

   task automatic test_stall;
      bit ok;
      load(8'h02, enc(4'h2, 4'h5, 4'h6, 4'h7, 8'h22));
      load(8'h03, 24'hF00000);
      expect_inst(8'h00, 24'h031210);
      expect_inst(8'h01, 24'h143111);
      expect_inst(8'h02, 24'h256722);
      go(8'h00);
      repeat (2) @(negedge clk);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vec++;
         if (valid !== 1'b1 || {pc_out, func, rd, rs1, rs2, addr} !== 32'h01143111) begin
            miss++;
            $display("FAIL stall_freeze: valid=%b got=%h required 1 01143111", valid, {pc_out, func, rd, rs1, rs2, addr});
         end
      end
      stall = 1'b0;
      @(negedge clk);
      vec++;
      if (valid !== 1'b1 || pc_out !== 8'h02) begin
         miss++;
         $display("FAIL stall_release: valid=%b pc_out=%h required 1 02", valid, pc_out);
      end
      wait_halt(ok);
      vec++;
      if (!ok || sb.size() != 0) begin
         miss++;
         $display("FAIL stall_drain: halted=%b pending=%0d required 1 0", halted, sb.size());
      end
   endtask

   task automatic test_jump;
      bit ok;
      load(8'h04, enc(4'h3, 4'h1, 4'h2, 4'h3, 8'h44));
      load(8'h05, enc(4'hE, 4'h0, 4'h0, 4'h0, 8'h40));
      load(8'h40, enc(4'hC, 4'h9, 4'hA, 4'hB, 8'h55));
      load(8'h41, enc(4'hD, 4'h8, 4'h7, 4'h6, 8'h66));
      load(8'h42, 24'hF00000);
      expect_inst(8'h04, 24'h312344);
      expect_inst(8'h40, 24'hC9AB55);
      expect_inst(8'h41, 24'hD87666);
      go(8'h04);
      @(negedge clk);
      @(negedge clk);
      vec++;
      if (valid !== 1'b0) begin
         miss++;
         $display("FAIL jump_bubble: valid=%b required 0", valid);
      end
      start = 1'b1;
      start_pc = 8'h99;
      @(negedge clk);
      start = 1'b0;
      vec++;
      if (valid !== 1'b1 || pc_out !== 8'h40) begin
         miss++;
         $display("FAIL jump_target: valid=%b pc_out=%h required 1 40", valid, pc_out);
      end
      wait_halt(ok);
      vec++;
      if (!ok || sb.size() != 0) begin
         miss++;
         $display("FAIL jump_drain: halted=%b pending=%0d required 1 0", halted, sb.size());
      end
   endtask

   task automatic test_wrap;
      bit ok;
      load(8'hFF, enc(4'h4, 4'h2, 4'h2, 4'h2, 8'hFE));
      load(8'h00, 24'hF00000);
      expect_inst(8'hFF, 24'h4222FE);
      go(8'hFF);
      wait_halt(ok);
      vec++;
      if (!ok || sb.size() != 0 || pc_out !== 8'hFF) begin
         miss++;
         $display("FAIL wrap: halted=%b pending=%0d pc_out=%h required 1 0 ff", halted, sb.size(), pc_out);
      end
   endtask

   task automatic test_reset_midrun;
      bit ok;
      for (int i = 0; i < 4; i++) load(8'h10 + 8'(i), enc(4'(i + 5), 4'(i), 4'(i + 1), 4'(i + 2), 8'(i + 8'h30)));
      load(8'h14, 24'hF00000);
      expect_inst(8'h10, enc(4'h5, 4'h0, 4'h1, 4'h2, 8'h30));
      expect_inst(8'h11, enc(4'h6, 4'h1, 4'h2, 4'h3, 8'h31));
      go(8'h10);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      stall = 1'b1;
      prog_we = 1'b1;
      prog_addr = 8'h12;
      prog_data = 24'hF00000;
      @(negedge clk);
      vec++;
      if ({func, rd, rs1, rs2, addr, pc_out, valid, busy, halted} !== 35'd0) begin
         miss++;
         $display("FAIL midrun_reset: got=%h required=0", {func, rd, rs1, rs2, addr, pc_out, valid, busy, halted});
      end
      rst_n = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      prog_we = 1'b0;
      repeat (4) @(negedge clk);
      vec++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         miss++;
         $display("FAIL midrun_quiet: busy=%b pending=%0d required 0 0", busy, sb.size());
      end
      for (int i = 0; i < 4; i++) expect_inst(8'h10 + 8'(i), enc(4'(i + 5), 4'(i), 4'(i + 1), 4'(i + 2), 8'(i + 8'h30)));
      go(8'h10);
      wait_halt(ok);
      vec++;
      if (!ok || sb.size() != 0) begin
         miss++;
         $display("FAIL midrun_restart: halted=%b pending=%0d required 1 0", halted, sb.size());
      end
   endtask

   task automatic test_prog_in_run;
      bit ok;
      load(8'h20, enc(4'h7, 4'h1, 4'h1, 4'h1, 8'hA0));
      load(8'h21, enc(4'h8, 4'h2, 4'h2, 4'h2, 8'hA1));
      load(8'h22, 24'hF00000);
      for (int r = 0; r < 2; r++) begin
         expect_inst(8'h20, 24'h7111A0);
         expect_inst(8'h21, 24'h8222A1);
         go(8'h20);
         if (r == 0) begin
            for (int i = 0; i < 3; i++) begin
               prog_we = 1'b1;
               prog_addr = 8'h20 + 8'(i);
               prog_data = 24'h0BBBBB;
               @(negedge clk);
            end
            prog_we = 1'b0;
         end
         wait_halt(ok);
         vec++;
         if (!ok || sb.size() != 0) begin
            miss++;
            $display("FAIL prog_in_run pass%0d: halted=%b pending=%0d required 1 0", r, halted, sb.size());
         end
      end
   endtask

   task automatic test_prog_with_start;
      bit ok;
      load(8'h31, 24'hF00000);
      expect_inst(8'h30, 24'h9ABC77);
      prog_we = 1'b1;
      prog_addr = 8'h30;
      prog_data = 24'h9ABC77;
      go(8'h30);
      prog_we = 1'b0;
      wait_halt(ok);
      vec++;
      if (!ok || sb.size() != 0) begin
         miss++;
         $display("FAIL prog_with_start: halted=%b pending=%0d required 1 0", halted, sb.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic;
      test_stall;
      test_jump;
      test_wrap;
      test_reset_midrun;
      test_prog_in_run;
      test_prog_with_start;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
